// File: rtl/wash_billing_if.sv
// Bus between the coin/credit front end and its environment.
// Signal direction prefixes are from the billing block's point of view.
interface wash_billing_if;
  logic        i_coin_a;
  logic        i_coin_b;
  logic [1:0]  i_mode;
  logic        i_start;
  logic        i_stop;
  logic        i_wash_done;
  logic        o_on;
  logic [10:0] o_bal;
  logic        o_overdrawn;
  logic        o_halted;

  modport master (
    output i_coin_a, i_coin_b, i_mode, i_start, i_stop, i_wash_done,
    input  o_on, o_bal, o_overdrawn, o_halted
  );

  modport slave (
    input  i_coin_a, i_coin_b, i_mode, i_start, i_stop, i_wash_done,
    output o_on, o_bal, o_overdrawn, o_halted
  );
endinterface

// File: rtl/wash_billing.sv
// Coin/credit front end for the washer: synchronises the buttons, keeps a
// signed balance with saturation at the display limit, charges the latched
// wash rate once per tick while running and drives the sequencer run enable.
module wash_billing #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int COIN_A_VAL = 1,
  parameter int COIN_B_VAL = 10,
  parameter int RATE_0     = 1,
  parameter int RATE_1     = 2,
  parameter int RATE_2     = 3,
  parameter int BAL_MAX    = 999,
  parameter int CREDIT_MIN = -20
) (
  input  logic          clk,
  input  logic          rst,
  wash_billing_if.slave bus
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0]      L_TICK_LAST  = CW'(CLK_HZ - 1);
  localparam logic signed [11:0] L_COIN_A     = 12'(COIN_A_VAL);
  localparam logic signed [11:0] L_COIN_B     = 12'(COIN_B_VAL);
  localparam logic signed [11:0] L_RATE_0     = 12'(RATE_0);
  localparam logic signed [11:0] L_RATE_1     = 12'(RATE_1);
  localparam logic signed [11:0] L_RATE_2     = 12'(RATE_2);
  localparam logic signed [11:0] L_BAL_MAX    = 12'(BAL_MAX);
  localparam logic signed [11:0] L_CREDIT_MIN = 12'(CREDIT_MIN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t             r_state, w_state_next;
  logic [10:0]        r_bal, w_bal_next;
  logic signed [11:0] r_rate, w_rate_next;
  logic [CW-1:0]      r_cnt, w_cnt_next;
  logic               r_on, r_halted, r_overdrawn;

  // Button pipeline bit order: {stop, start, coin_b, coin_a}
  logic [3:0]         r_sync1, r_sync2, r_prev;
  logic [3:0]         w_raw, w_press;

  logic signed [11:0] w_bal_ext, w_coins, w_sum, w_charged, w_bal_pre, w_mode_rate;
  logic               w_tick;

  // Heavy rate covers both mode 2 and mode 3.
  function automatic logic signed [11:0] rate_of(input logic [1:0] m);
    logic signed [11:0] r;
    case (m)
      2'd0:    r = L_RATE_0;
      2'd1:    r = L_RATE_1;
      default: r = L_RATE_2;
    endcase
    return r;
  endfunction

  assign w_raw       = {bus.i_stop, bus.i_start, bus.i_coin_b, bus.i_coin_a};
  assign w_press     = r_sync2 & ~r_prev;
  assign w_bal_ext   = {r_bal[10], r_bal};
  assign w_coins     = (w_press[0] ? L_COIN_A : 12'sd0) + (w_press[1] ? L_COIN_B : 12'sd0);
  assign w_sum       = w_bal_ext + w_coins;
  assign w_charged   = w_sum - r_rate;
  assign w_mode_rate = rate_of(bus.i_mode);
  assign w_tick      = (r_state == S_RUN) && (r_cnt == L_TICK_LAST);

  // Two-flop synchroniser plus edge register for the raw button levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 4'b0000;
      r_sync2 <= 4'b0000;
      r_prev  <= 4'b0000;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Next state, next balance (coins always credited) and tick counter.
  always_comb begin
    w_state_next = r_state;
    w_rate_next  = r_rate;
    w_cnt_next   = r_cnt;
    w_bal_pre    = w_sum;
    case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        if (w_press[2] && (w_bal_ext >= w_mode_rate)) begin
          w_state_next = S_RUN;
          w_rate_next  = w_mode_rate;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_press[3]) begin
          // Abort wins over a charge falling on the same cycle.
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else if (bus.i_wash_done) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else if (w_tick && (w_charged < L_CREDIT_MIN)) begin
          // Charging would break the overdraft floor: stop without charging.
          w_state_next = S_HALT;
        end else if (w_tick) begin
          w_bal_pre  = w_charged;
          w_cnt_next = '0;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      S_HALT: begin
        if (w_press[3]) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else if (w_sum >= r_rate) begin
          w_state_next = S_RUN;
          w_cnt_next   = '0;
        end else begin
          w_state_next = S_HALT;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase

    // Saturate at the display limit instead of wrapping.
    if (w_bal_pre > L_BAL_MAX) begin
      w_bal_next = L_BAL_MAX[10:0];
    end else begin
      w_bal_next = w_bal_pre[10:0];
    end
  end

  // State, balance and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_bal       <= 11'd0;
      r_rate      <= L_RATE_0;
      r_cnt       <= '0;
      r_on        <= 1'b0;
      r_halted    <= 1'b0;
      r_overdrawn <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_bal       <= w_bal_next;
      r_rate      <= w_rate_next;
      r_cnt       <= w_cnt_next;
      r_on        <= (w_state_next == S_RUN);
      r_halted    <= (w_state_next == S_HALT);
      r_overdrawn <= w_bal_next[10];
    end
  end

  assign bus.o_on        = r_on;
  assign bus.o_bal       = r_bal;
  assign bus.o_overdrawn = r_overdrawn;
  assign bus.o_halted    = r_halted;

endmodule

// File: tb/tb_wash_billing.sv
// Self-checking bench for wash_billing with a 10-cycle charge tick.
// Expected snapshots {on, halted, overdrawn, bal} are queued when stimulus
// is applied and popped when the DUT output is sampled.
module tb_wash_billing;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    string      name;
    logic [13:0] v;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  wash_billing_if bus ();

  wash_billing #(.CLK_HZ(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wire [13:0] w_obs = {bus.o_on, bus.o_halted, bus.o_overdrawn, bus.o_bal};

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queue an expected snapshot; overdrawn follows the sign of the balance.
  task automatic push_exp(input string n, input logic on, input logic hl, input int b);
    exp_t x;
    logic [10:0] bb;
    bb   = b[10:0];
    x.name = n;
    x.v  = {on, hl, bb[10], bb};
    sb.push_back(x);
  endtask

  // 0=coin_a 1=coin_b 2=start 3=stop; rising edge then release.
  task automatic press(input int which);
    case (which)
      0: bus.i_coin_a = 1'b1;
      1: bus.i_coin_b = 1'b1;
      2: bus.i_start  = 1'b1;
      default: bus.i_stop = 1'b1;
    endcase
    step(2);
    bus.i_coin_a = 1'b0;
    bus.i_coin_b = 1'b0;
    bus.i_start  = 1'b0;
    bus.i_stop   = 1'b0;
    step(3);
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    bus.i_coin_a = 1'b0; bus.i_coin_b = 1'b0; bus.i_mode = 2'd0;
    bus.i_start = 1'b0; bus.i_stop = 1'b0; bus.i_wash_done = 1'b0;
    rst = 1'b1;
    push_exp("reset_held", 1'b0, 1'b0, 0);
    step(3);
    e = sb.pop_front(); checks++;
    if (w_obs !== e.v) begin errors++; $display("FAIL %s: got %h bal=%0d, expected %h bal=%0d", e.name, w_obs, $signed(w_obs[10:0]), e.v, $signed(e.v[10:0])); end
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_coins();
    int seq[5] = '{1, 1, 0, 0, 0};
    int bal = 0;
    foreach (seq[i]) begin
      bal += (seq[i] == 1) ? 10 : 1;
      push_exp($sformatf("coin_%0d", i), 1'b0, 1'b0, bal);
      press(seq[i]);
      e = sb.pop_front(); checks++;
      if (w_obs !== e.v) begin errors++; $display("FAIL %s: got %h bal=%0d, expected %h bal=%0d", e.name, w_obs, $signed(w_obs[10:0]), e.v, $signed(e.v[10:0])); end
    end
  endtask

  task automatic test_run_charge();
    int names_off[4] = '{9, 10, 29, 30};
    int bals[4]      = '{23, 21, 19, 17};
    bus.i_mode = 2'd1;
    bus.i_start = 1'b1;
    push_exp("start_not_yet", 1'b0, 1'b0, 23);
    step(2);
    e = sb.pop_front(); checks++;
    if (w_obs !== e.v) begin errors++; $display("FAIL %s: got %h bal=%0d, expected %h bal=%0d", e.name, w_obs, $signed(w_obs[10:0]), e.v, $signed(e.v[10:0])); end
    bus.i_start = 1'b0;
    push_exp("run_on", 1'b1, 1'b0, 23);
    step(2); // entry + 1
    e = sb.pop_front(); checks++;
    if (w_obs !== e.v) begin errors++; $display("FAIL %s: got %h bal=%0d, expected %h bal=%0d", e.name, w_obs, $signed(w_obs[10:0]), e.v, $signed(e.v[10:0])); end
    for (int i = 0; i < 4; i++) begin
      push_exp($sformatf("run_charge_t%0d", names_off[i]), 1'b1, 1'b0, bals[i]);
      step(names_off[i] - ((i == 0) ? 1 : names_off[i-1]));
      e = sb.pop_front(); checks++;
      if (w_obs !== e.v) begin errors++; $display("FAIL %s: got %h bal=%0d, expected %h bal=%0d", e.name, w_obs, $signed(w_obs[10:0]), e.v, $signed(e.v[10:0])); end
    end
    bus.i_wash_done = 1'b1;
    push_exp("wash_done_idle", 1'b0, 1'b0, 17);
    step(1);
    bus.i_wash_done = 1'b0;
    e = sb.pop_front(); checks++;
    if (w_obs !== e.v) begin errors++; $display("FAIL %s: got %h bal=%0d, expected %h bal=%0d", e.name, w_obs, $signed(w_obs[10:0]), e.v, $signed(e.v[10:0])); end
  endtask

  task automatic test_halt();
    rst_pulse();
    press(0);
    press(0);
    bus.i_mode = 2'd2;
    push_exp("start_insufficient", 1'b0, 1'b0, 2);
    press(2);
    step(3);
    e = sb.pop_front(); checks++;
    if (w_obs !== e.v) begin errors++; $display("FAIL %s: got %h bal=%0d, expected %h bal=%0d", e.name, w_obs, $signed(w_obs[10:0]), e.v, $signed(e.v[10:0])); end
    press(0);
    bus.i_start = 1'b1;
    step(2);
    bus.i_start = 1'b0;
    push_exp("heavy_run", 1'b1, 1'b0, 3);
    step(1); // entry
    e = sb.pop_front(); checks++;
    if (w_obs !== e.v) begin errors++; $display("FAIL %s: got %h bal=%0d, expected %h bal=%0d", e.name, w_obs, $signed(w_obs[10:0]), e.v, $signed(e.v[10:0])); end
    push_exp("heavy_first_tick", 1'b1, 1'b0, 0);
    step(10);
    e = sb.pop_front(); checks++;
    if (w_obs !== e.v) begin errors++; $display("FAIL %s: got %h bal=%0d, expected %h bal=%0d", e.name, w_obs, $signed(w_obs[10:0]), e.v, $signed(e.v[10:0])); end
    push_exp("overdraft_run", 1'b1, 1'b0, -18);
    step(69);
    e = sb.pop_front(); checks++;
    if (w_obs !== e.v) begin errors++; $display("FAIL %s: got %h bal=%0d, expected %h bal=%0d", e.name, w_obs, $signed(w_obs[10:0]), e.v, $signed(e.v[10:0])); end
    push_exp("halt_floor", 1'b0, 1'b1, -18);
    step(1);
    e = sb.pop_front(); checks++;
    if (w_obs !== e.v) begin errors++; $display("FAIL %s: got %h bal=%0d, expected %h bal=%0d", e.name, w_obs, $signed(w_obs[10:0]), e.v, $signed(e.v[10:0])); end
  endtask

  task automatic test_resume();
    push_exp("halt_coin1", 1'b0, 1'b1, -8);
    press(1);
    e = sb.pop_front(); checks++;
    if (w_obs !== e.v) begin errors++; $display("FAIL %s: got %h bal=%0d, expected %h bal=%0d", e.name, w_obs, $signed(w_obs[10:0]), e.v, $signed(e.v[10:0])); end
    push_exp("halt_coin2", 1'b0, 1'b1, 2);
    press(1);
    e = sb.pop_front(); checks++;
    if (w_obs !== e.v) begin errors++; $display("FAIL %s: got %h bal=%0d, expected %h bal=%0d", e.name, w_obs, $signed(w_obs[10:0]), e.v, $signed(e.v[10:0])); end
    bus.i_coin_a = 1'b1;
    step(2);
    bus.i_coin_a = 1'b0;
    push_exp("resume_run", 1'b1, 1'b0, 3);
    step(1);
    e = sb.pop_front(); checks++;
    if (w_obs !== e.v) begin errors++; $display("FAIL %s: got %h bal=%0d, expected %h bal=%0d", e.name, w_obs, $signed(w_obs[10:0]), e.v, $signed(e.v[10:0])); end
    push_exp("resume_pre_tick", 1'b1, 1'b0, 3);
    step(9);
    e = sb.pop_front(); checks++;
    if (w_obs !== e.v) begin errors++; $display("FAIL %s: got %h bal=%0d, expected %h bal=%0d", e.name, w_obs, $signed(w_obs[10:0]), e.v, $signed(e.v[10:0])); end
    push_exp("resume_tick", 1'b1, 1'b0, 0);
    step(1);
    e = sb.pop_front(); checks++;
    if (w_obs !== e.v) begin errors++; $display("FAIL %s: got %h bal=%0d, expected %h bal=%0d", e.name, w_obs, $signed(w_obs[10:0]), e.v, $signed(e.v[10:0])); end
    push_exp("stop_idle", 1'b0, 1'b0, 0);
    press(3);
    e = sb.pop_front(); checks++;
    if (w_obs !== e.v) begin errors++; $display("FAIL %s: got %h bal=%0d, expected %h bal=%0d", e.name, w_obs, $signed(w_obs[10:0]), e.v, $signed(e.v[10:0])); end
  endtask

  task automatic test_clamp();
    rst_pulse();
    for (int i = 0; i < 99; i++) press(1);
    for (int i = 0; i < 5; i++) press(0);
    push_exp("bal_995", 1'b0, 1'b0, 995);
    e = sb.pop_front(); checks++;
    if (w_obs !== e.v) begin errors++; $display("FAIL %s: got %h bal=%0d, expected %h bal=%0d", e.name, w_obs, $signed(w_obs[10:0]), e.v, $signed(e.v[10:0])); end
    push_exp("clamp_b", 1'b0, 1'b0, 999);
    press(1);
    e = sb.pop_front(); checks++;
    if (w_obs !== e.v) begin errors++; $display("FAIL %s: got %h bal=%0d, expected %h bal=%0d", e.name, w_obs, $signed(w_obs[10:0]), e.v, $signed(e.v[10:0])); end
    push_exp("clamp_a", 1'b0, 1'b0, 999);
    press(0);
    e = sb.pop_front(); checks++;
    if (w_obs !== e.v) begin errors++; $display("FAIL %s: got %h bal=%0d, expected %h bal=%0d", e.name, w_obs, $signed(w_obs[10:0]), e.v, $signed(e.v[10:0])); end
    rst_pulse();
    bus.i_coin_a = 1'b1;
    bus.i_coin_b = 1'b1;
    push_exp("both_coins", 1'b0, 1'b0, 11);
    step(2);
    bus.i_coin_a = 1'b0;
    bus.i_coin_b = 1'b0;
    step(3);
    e = sb.pop_front(); checks++;
    if (w_obs !== e.v) begin errors++; $display("FAIL %s: got %h bal=%0d, expected %h bal=%0d", e.name, w_obs, $signed(w_obs[10:0]), e.v, $signed(e.v[10:0])); end
  endtask

  task automatic test_rst_and_stop_tick();
    rst_pulse();
    press(1);
    bus.i_mode = 2'd0;
    bus.i_start = 1'b1;
    step(2);
    bus.i_start = 1'b0;
    step(1);
    step(5);
    #2;
    rst = 1'b1;
    push_exp("async_rst", 1'b0, 1'b0, 0);
    #1;
    e = sb.pop_front(); checks++;
    if (w_obs !== e.v) begin errors++; $display("FAIL %s: got %h bal=%0d, expected %h bal=%0d", e.name, w_obs, $signed(w_obs[10:0]), e.v, $signed(e.v[10:0])); end
    #2;
    rst = 1'b0;
    step(1);
    press(1);
    bus.i_start = 1'b1;
    step(2);
    bus.i_start = 1'b0;
    push_exp("run_again", 1'b1, 1'b0, 10);
    step(1); // entry
    e = sb.pop_front(); checks++;
    if (w_obs !== e.v) begin errors++; $display("FAIL %s: got %h bal=%0d, expected %h bal=%0d", e.name, w_obs, $signed(w_obs[10:0]), e.v, $signed(e.v[10:0])); end
    step(7);
    bus.i_stop   = 1'b1;
    bus.i_coin_a = 1'b1;
    push_exp("stop_on_tick", 1'b0, 1'b0, 11);
    step(2);
    bus.i_stop   = 1'b0;
    bus.i_coin_a = 1'b0;
    step(1);
    e = sb.pop_front(); checks++;
    if (w_obs !== e.v) begin errors++; $display("FAIL %s: got %h bal=%0d, expected %h bal=%0d", e.name, w_obs, $signed(w_obs[10:0]), e.v, $signed(e.v[10:0])); end
    push_exp("idle_holds", 1'b0, 1'b0, 11);
    step(20);
    e = sb.pop_front(); checks++;
    if (w_obs !== e.v) begin errors++; $display("FAIL %s: got %h bal=%0d, expected %h bal=%0d", e.name, w_obs, $signed(w_obs[10:0]), e.v, $signed(e.v[10:0])); end
  endtask

  initial begin
    test_reset();
    test_coins();
    test_run_charge();
    test_halt();
    test_resume();
    test_clamp();
    test_rst_and_stop_tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion by 200000 time units, expected finish");
    $fatal(1);
  end
endmodule
